// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared AXI3 types, widths and helpers for the APB-to-AXI bridge.
package apb2axi_pkg;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam logic [12:0] AXI_4KB = 13'd4096;

    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi_resp_e;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} axi_burst_e;
    typedef enum logic [2:0] {IDLE, CHECK, XFER, WAIT_B, CPL} wr_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
    } wr_req_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        axi_resp_e           resp;
    } wr_cpl_t;

    // 13-bit sum so that a burst ending exactly on the boundary is still legal
    function automatic logic crosses_4kb(input logic [11:0] offs, input logic [3:0] len, input logic [2:0] size);
        logic [12:0] bytes;
        bytes = ({9'd0, len} + 13'd1) << size;
        return ({1'b0, offs} + bytes) > AXI_4KB;
    endfunction
endpackage

// File: rtl/apb2axi_wr_beat_ctr.sv
// apb2axi_wr_beat_ctr: counts W beats of one burst, flags the last beat and burst completion.
module apb2axi_wr_beat_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       inc,
    input  logic [3:0] len,
    output logic [4:0] cnt,
    output logic       last,
    output logic       done
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (inc && !done)
            cnt <= cnt + 5'd1;
    end

    assign last = cnt == {1'b0, len};
    assign done = cnt > {1'b0, len};
endmodule

// File: rtl/apb2axi_axi_wr_sequencer.sv
// apb2axi_axi_wr_sequencer: runs one AXI3 write burst at a time (AW, W, B) from a request
// descriptor and data FIFO, returning a completion record; illegal bursts never reach AXI.
module apb2axi_axi_wr_sequencer
    import apb2axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_id,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic [2:0]        req_size,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [STRB_W-1:0] wd_strb,
    output logic              cpl_valid,
    input  logic              cpl_ready,
    output logic [ID_W-1:0]   cpl_id,
    output logic [1:0]        cpl_resp,
    output logic              err_bid,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic [1:0]        AWLOCK,
    output logic [3:0]        AWCACHE,
    output logic [2:0]        AWPROT,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ID_W-1:0]   WID,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);
    wr_state_e         state, state_nx;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        resp_q;
    logic              aw_done_q, err_q;
    logic [4:0]        beat_cnt;
    logic              w_done, in_xfer, aw_hs, w_hs, illegal, xfer_end, bid_bad;

    apb2axi_wr_beat_ctr u_beat_ctr (
        .clk  (ACLK),
        .rst_n(ARESETn),
        .load (state == CHECK),
        .inc  (w_hs),
        .len  (len_q),
        .cnt  (beat_cnt),
        .last (WLAST),
        .done (w_done)
    );

    // VALIDs decode straight from state so an asynchronous reset drops them at once
    assign in_xfer  = state == XFER;
    assign AWVALID  = in_xfer && !aw_done_q;
    assign WVALID   = in_xfer && !w_done && wd_valid;
    assign wd_ready = in_xfer && !w_done && WREADY;
    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign xfer_end = (aw_done_q || aw_hs) && (w_done || (w_hs && WLAST));
    assign illegal  = (size_q > 3'($clog2(STRB_W))) || crosses_4kb(addr_q[11:0], len_q, size_q);
    assign bid_bad  = BID != id_q;

    assign req_ready = (state == IDLE) && ARESETn;
    assign BREADY    = state == WAIT_B;
    assign cpl_valid = state == CPL;
    assign cpl_id    = id_q;
    assign cpl_resp  = resp_q;
    assign err_bid   = err_q;
    assign AWID      = id_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWBURST   = INCR;
    assign AWLOCK    = 2'b00;
    assign AWCACHE   = 4'b0011;
    assign AWPROT    = 3'b000;
    assign WID       = id_q;
    assign WDATA     = wd_data;
    assign WSTRB     = wd_strb;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? CHECK : IDLE;
            CHECK:   state_nx = illegal ? CPL : XFER;
            XFER:    state_nx = xfer_end ? WAIT_B : XFER;
            WAIT_B:  state_nx = BVALID ? CPL : WAIT_B;
            CPL:     state_nx = cpl_ready ? IDLE : CPL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            resp_q    <= '0;
            aw_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= 1'b0;
            if (req_valid && req_ready) begin
                id_q   <= req_id;
                addr_q <= req_addr;
                len_q  <= req_len;
                size_q <= req_size;
            end
            if (state == CHECK) begin
                aw_done_q <= 1'b0;
                if (illegal)
                    resp_q <= SLVERR;
            end
            if (aw_hs)
                aw_done_q <= 1'b1;
            if (state == WAIT_B && BVALID) begin
                resp_q <= bid_bad ? SLVERR : BRESP;
                err_q  <= bid_bad;
            end
        end
    end
endmodule
